exc_commit_ctrl: RTL and testbench
==================================

Name: exc_commit_ctrl

Overview:
Precise-exception sequencer at the writeback boundary of the 5-stage MIPS pipeline. Samples the instruction committing in WB, decides exception / interrupt / ERET, kills its register write, and drives the CP0 exception-update strobe. Raises the pipeline flush and issues the fetch redirect, then holds the pipeline in a drain window until refetch.

Parameters:
EXC_VECTOR, 32'hbfc00380, redirect target for exceptions and interrupts.
FLUSH_CYCLES, 2, cycles flush stays asserted (FLUSH plus DRAIN); legal range 1..15.

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
ws_valid  input  1  WB holds a valid instruction this cycle
ws_exc  input  1  instruction carries a synchronous exception
ws_exccode  input  5  ExcCode of that exception
ws_eret  input  1  instruction is ERET
ws_bd  input  1  instruction is in a branch delay slot
ws_pc  input  32  instruction PC
ws_badvaddr  input  32  faulting address (AdEL/AdES)
cp0_status_ie  input  1  Status.IE
cp0_status_exl  input  1  Status.EXL
cp0_int_pending  input  8  Cause.IP & Status.IM
cp0_epc  input  32  current EPC
commit_kill  output  1  suppress RF write / commit of WB instruction (combinational)
cp0_exc_we  output  1  one-cycle CP0 exception update strobe
cp0_exc_code  output  5  ExcCode to Cause
cp0_exc_bd  output  1  Cause.BD
cp0_exc_epc  output  32  EPC value (ws_pc, or ws_pc-4 when bd)
cp0_exc_badvaddr  output  32  BadVAddr value
cp0_eret_we  output  1  one-cycle strobe: clear Status.EXL
flush  output  1  flush IF/ID/EX/MEM
redirect_valid  output  1  one-cycle fetch redirect
redirect_pc  output  32  redirect target

Behaviour:
- int_take = ws_valid & cp0_status_ie & ~cp0_status_exl & |cp0_int_pending, evaluated only in IDLE.
- Priority in IDLE: int_take (ExcCode 0) > ws_exc > ws_eret. An instruction with both ws_exc and ws_eret is treated as an exception.
- commit_kill = IDLE & ws_valid & (int_take | ws_exc). It is 0 for ERET because ERET has no RF write. It is 0 in every other state.
- FSM states: IDLE, FLUSH, DRAIN.
- IDLE -> FLUSH on any event (int_take | ws_valid&ws_exc | ws_valid&ws_eret). The event type, code, bd, pc, and badvaddr are registered on that edge.
- FLUSH lasts exactly 1 cycle:
  - flush=1 and redirect_valid=1.
  - Exception/interrupt: cp0_exc_we=1, redirect_pc=EXC_VECTOR.
  - ERET: cp0_eret_we=1, redirect_pc=cp0_epc sampled in FLUSH. EPC is not updated by this block.
- FLUSH -> DRAIN when FLUSH_CYCLES>1, else -> IDLE.
- DRAIN: flush=1, all strobes 0. A 4-bit down-counter is loaded with FLUSH_CYCLES-2 on entry and returns to IDLE when it reads 0. All ws_* inputs are ignored.
- cp0_exc_epc = bd ? pc-32'd4 : pc (modulo 2^32). cp0_exc_badvaddr = registered ws_badvaddr, or 0 for interrupts.
- Data outputs are held between events (last registered values) and are meaningful only while their strobe is high.
- Reset: state IDLE, counter 0. All 1-bit outputs 0, all vectors 0, redirect_pc 0.
- Reset asserted mid-FLUSH/DRAIN aborts immediately: outputs take reset values asynchronously and no strobe fires after release.
- Back-to-back events: an event arriving in FLUSH/DRAIN is dropped. Upstream stages are flushed, so only a refetched instruction can raise the next event.
- Minimum spacing between two redirect_valid pulses: FLUSH_CYCLES+1 cycles.

Optional Feature:
Macro EXC_STAT_EN.
- Defined:
  - Adds outputs exc_count[31:0] (increments on each cp0_exc_we) and eret_count[31:0] (increments on each cp0_eret_we).
  - Both wrap 32'hffffffff -> 0 and reset to 0.
- Undefined: both ports and counters are absent. Core behaviour is identical.

Test Plan:
1. Syscall (ws_valid=1, ws_exc=1, code 5'h08, pc 32'hbfc00100, bd=0) in cycle N -> commit_kill=1 in N. In N+1: cp0_exc_we=1, code 8, epc 32'hbfc00100, redirect_pc 32'hbfc00380, flush=1. With FLUSH_CYCLES=2, flush=1 in N+2 and the FSM is IDLE in N+3.
2. Delay-slot AdEL (bd=1, pc 32'hbfc00204, badvaddr 32'h00000003) -> cp0_exc_epc 32'hbfc00200, cp0_exc_bd=1, cp0_exc_badvaddr 32'h00000003.
3. ERET with cp0_epc=32'hbfc00420 -> commit_kill=0, cp0_eret_we=1, cp0_exc_we=0, redirect_pc 32'hbfc00420.
4. cp0_int_pending=8'h80, IE=1, EXL=0, and ws_exc=1 (code 5'h0c) in the same cycle -> code 0, interrupt wins. Repeat with EXL=1 -> code 5'h0c.
5. Second ws_exc presented during DRAIN -> ignored: no commit_kill, no extra redirect_valid pulse.
6. resetn pulsed low during FLUSH -> flush, redirect_valid, and cp0_exc_we all drop to 0 without waiting for clk. IDLE after release; with EXC_STAT_EN, exc_count=0.

Source files
------------

// File: rtl/exc_commit_ctrl_if.sv
// Writeback commit bus between the WB stage and the precise-exception sequencer.
// The sequencer is the slave: it observes ws_* and returns the commit kill.
interface exc_commit_ctrl_if;
  logic        ws_valid;
  logic        ws_exc;
  logic [4:0]  ws_exccode;
  logic        ws_eret;
  logic        ws_bd;
  logic [31:0] ws_pc;
  logic [31:0] ws_badvaddr;
  logic        commit_kill;

  modport master (
    output ws_valid, ws_exc, ws_exccode, ws_eret, ws_bd, ws_pc, ws_badvaddr,
    input  commit_kill
  );

  modport slave (
    input  ws_valid, ws_exc, ws_exccode, ws_eret, ws_bd, ws_pc, ws_badvaddr,
    output commit_kill
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Precise-exception / interrupt / ERET sequencer at the WB boundary: kills the commit,
// strobes CP0, flushes and redirects fetch. Optional EXC_STAT_EN adds event counters.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  exc_commit_ctrl_if.slave     ws,
  input  logic                 cp0_status_ie,
  input  logic                 cp0_status_exl,
  input  logic [7:0]           cp0_int_pending,
  input  logic [31:0]          cp0_epc,
  output logic                 cp0_exc_we,
  output logic [4:0]           cp0_exc_code,
  output logic                 cp0_exc_bd,
  output logic [31:0]          cp0_exc_epc,
  output logic [31:0]          cp0_exc_badvaddr,
  output logic                 cp0_eret_we,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc
`ifdef EXC_STAT_EN
  ,
  output logic [31:0]          exc_count,
  output logic [31:0]          eret_count
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  localparam bit         HAS_DRAIN  = (FLUSH_CYCLES > 1);
  localparam logic [3:0] DRAIN_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t      state;
  logic [3:0]  drain_cnt;
  logic        is_eret;
  logic [31:0] redirect_pc_q;
  logic        int_take;
  logic        exc_evt;
  logic        eret_evt;

  // Event detection is only live in IDLE; anything seen during FLUSH/DRAIN is dropped.
  always_comb begin
    int_take = (state == IDLE) & ws.ws_valid & cp0_status_ie & ~cp0_status_exl
               & (|cp0_int_pending);
    exc_evt  = (state == IDLE) & ws.ws_valid & ws.ws_exc;
    eret_evt = (state == IDLE) & ws.ws_valid & ws.ws_eret;
  end

  assign ws.commit_kill = int_take | exc_evt;

  // ERET target is EPC as seen during the FLUSH cycle itself, so it bypasses the register.
  assign redirect_pc = (state == FLUSH && is_eret) ? cp0_epc : redirect_pc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      drain_cnt        <= 4'd0;
      is_eret          <= 1'b0;
      redirect_pc_q    <= 32'd0;
      cp0_exc_we       <= 1'b0;
      cp0_exc_code     <= 5'd0;
      cp0_exc_bd       <= 1'b0;
      cp0_exc_epc      <= 32'd0;
      cp0_exc_badvaddr <= 32'd0;
      cp0_eret_we      <= 1'b0;
      flush            <= 1'b0;
      redirect_valid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (int_take || exc_evt) begin
            state            <= FLUSH;
            is_eret          <= 1'b0;
            flush            <= 1'b1;
            redirect_valid   <= 1'b1;
            cp0_exc_we       <= 1'b1;
            cp0_exc_code     <= int_take ? 5'd0 : ws.ws_exccode;
            cp0_exc_bd       <= ws.ws_bd;
            cp0_exc_epc      <= ws.ws_bd ? (ws.ws_pc - 32'd4) : ws.ws_pc;
            cp0_exc_badvaddr <= int_take ? 32'd0 : ws.ws_badvaddr;
            redirect_pc_q    <= EXC_VECTOR;
          end else if (eret_evt) begin
            state          <= FLUSH;
            is_eret        <= 1'b1;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            cp0_eret_we    <= 1'b1;
          end
        end
        FLUSH: begin
          cp0_exc_we     <= 1'b0;
          cp0_eret_we    <= 1'b0;
          redirect_valid <= 1'b0;
          if (is_eret) redirect_pc_q <= cp0_epc;
          if (HAS_DRAIN) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            state <= IDLE;
            flush <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXC_STAT_EN
  // Event statistics; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_count  <= 32'd0;
      eret_count <= 32'd0;
    end else begin
      if (cp0_exc_we)  exc_count  <= exc_count + 32'd1;
      if (cp0_eret_we) eret_count <= eret_count + 32'd1;
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: directed cases plus randomized WB traffic
// checked against a cycle-count reference model of the exception sequencing rules.
module tb_exc_commit_ctrl;
  localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;
  localparam int          FC         = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cp0_status_ie, cp0_status_exl;
  logic [7:0]  cp0_int_pending;
  logic [31:0] cp0_epc;
  logic        cp0_exc_we, cp0_exc_bd, cp0_eret_we, flush, redirect_valid;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_exc_epc, cp0_exc_badvaddr, redirect_pc;
`ifdef EXC_STAT_EN
  logic [31:0] exc_count, eret_count;
`endif

  exc_commit_ctrl_if wsif ();

  always #5 clk = ~clk;

  exc_commit_ctrl #(.EXC_VECTOR(EXC_VECTOR), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn), .ws(wsif),
    .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl),
    .cp0_int_pending(cp0_int_pending), .cp0_epc(cp0_epc),
    .cp0_exc_we(cp0_exc_we), .cp0_exc_code(cp0_exc_code), .cp0_exc_bd(cp0_exc_bd),
    .cp0_exc_epc(cp0_exc_epc), .cp0_exc_badvaddr(cp0_exc_badvaddr),
    .cp0_eret_we(cp0_eret_we), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef EXC_STAT_EN
    , .exc_count(exc_count), .eret_count(eret_count)
`endif
  );

  typedef struct { logic kill; logic flush; logic rv; logic exc_we; logic eret_we; } cyc_exp_t;
  typedef struct { logic is_eret; logic [4:0] code; logic bd; logic [31:0] epc; logic [31:0] bva; logic [31:0] target; } redir_t;

  cyc_exp_t cq[$];
  redir_t   rq[$];
  int       errors = 0, checks = 0;
  bit       mon_en = 1'b0;
  int       cyc = 0, flush_end = -1;
  bit       pend = 1'b0;
  redir_t   pend_r;
  int       exp_exc_n = 0, exp_eret_n = 0;
  cyc_exp_t mx;
  redir_t   mr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One WB cycle of stimulus; the model decides what the DUT must show this cycle.
  task automatic step(input logic v, input logic e, input logic [4:0] code, input logic er,
                      input logic bd, input logic [31:0] pc, input logic [31:0] bva,
                      input logic ie, input logic exl, input logic [7:0] ip,
                      input logic [31:0] epc);
    cyc_exp_t x;
    redir_t   r;
    logic     it;
    @(posedge clk); #1;
    cyc++;
    wsif.ws_valid = v; wsif.ws_exc = e; wsif.ws_exccode = code; wsif.ws_eret = er;
    wsif.ws_bd = bd; wsif.ws_pc = pc; wsif.ws_badvaddr = bva;
    cp0_status_ie = ie; cp0_status_exl = exl; cp0_int_pending = ip; cp0_epc = epc;
    x.kill = 1'b0; x.flush = (cyc <= flush_end); x.rv = 1'b0; x.exc_we = 1'b0; x.eret_we = 1'b0;
    if (pend) begin
      pend_r.target = pend_r.is_eret ? epc : EXC_VECTOR;
      rq.push_back(pend_r);
      x.rv = 1'b1; x.exc_we = !pend_r.is_eret; x.eret_we = pend_r.is_eret;
      if (pend_r.is_eret) exp_eret_n++; else exp_exc_n++;
      pend = 1'b0;
    end
    if (cyc > flush_end) begin
      it = v && ie && !exl && (ip != 8'd0);
      r.is_eret = 1'b0; r.code = it ? 5'd0 : code; r.bd = bd;
      r.epc = bd ? pc - 32'd4 : pc; r.bva = it ? 32'd0 : bva; r.target = 32'd0;
      if (v && (it || e)) begin
        x.kill = 1'b1; pend = 1'b1; pend_r = r; flush_end = cyc + FC;
      end else if (v && er) begin
        r.is_eret = 1'b1; pend = 1'b1; pend_r = r; flush_end = cyc + FC;
      end
    end
    cq.push_back(x);
  endtask

  task automatic idle(input int n, input logic [31:0] epc);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 0, 0, 32'd0, 32'd0, 0, 0, 8'd0, epc);
  endtask

  // Monitor: compares every cycle's outputs and pops redirect payloads on redirect_valid.
  always @(negedge clk) begin
    if (mon_en && cq.size() > 0) begin
      mx = cq.pop_front();
      chk("commit_kill", 32'(wsif.commit_kill), 32'(mx.kill));
      chk("flush", 32'(flush), 32'(mx.flush));
      chk("redirect_valid", 32'(redirect_valid), 32'(mx.rv));
      chk("cp0_exc_we", 32'(cp0_exc_we), 32'(mx.exc_we));
      chk("cp0_eret_we", 32'(cp0_eret_we), 32'(mx.eret_we));
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL redirect_unexpected: got pc %h expected no redirect", redirect_pc);
        end else begin
          mr = rq.pop_front();
          chk("redirect_pc", redirect_pc, mr.target);
          if (!mr.is_eret) begin
            chk("cp0_exc_code", 32'(cp0_exc_code), 32'(mr.code));
            chk("cp0_exc_bd", 32'(cp0_exc_bd), 32'(mr.bd));
            chk("cp0_exc_epc", cp0_exc_epc, mr.epc);
            chk("cp0_exc_badvaddr", cp0_exc_badvaddr, mr.bva);
          end
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    wsif.ws_valid = 0; wsif.ws_exc = 0; wsif.ws_exccode = 0; wsif.ws_eret = 0;
    wsif.ws_bd = 0; wsif.ws_pc = 0; wsif.ws_badvaddr = 0;
    cp0_status_ie = 0; cp0_status_exl = 0; cp0_int_pending = 0; cp0_epc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_exc_we", 32'(cp0_exc_we), 32'd0);
    chk("rst_eret_we", 32'(cp0_eret_we), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_exc_epc", cp0_exc_epc, 32'd0);
    chk("rst_exc_code", 32'(cp0_exc_code), 32'd0);
    @(negedge clk) resetn = 1'b1;

    // Reset asserted in the middle of FLUSH must drop everything without a clock edge.
    @(posedge clk); #1;
    wsif.ws_valid = 1; wsif.ws_exc = 1; wsif.ws_exccode = 5'h08; wsif.ws_pc = 32'hbfc00100;
    @(posedge clk); #1;
    wsif.ws_valid = 0; wsif.ws_exc = 0;
    chk("pre_rst_flush", 32'(flush), 32'd1);
    chk("pre_rst_exc_we", 32'(cp0_exc_we), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_flush", 32'(flush), 32'd0);
    chk("async_rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("async_rst_exc_we", 32'(cp0_exc_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_flush", 32'(flush), 32'd0);
      chk("post_rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("post_rst_exc_we", 32'(cp0_exc_we), 32'd0);
    end
`ifdef EXC_STAT_EN
    chk("post_rst_exc_count", exc_count, 32'd0);
`endif

    flush_end = cyc;
    mon_en = 1'b1;
    // Syscall, delay-slot AdEL, ERET
    step(1, 1, 5'h08, 0, 0, 32'hbfc00100, 32'd0, 0, 0, 8'd0, 32'd0);
    idle(4, 32'd0);
    step(1, 1, 5'h04, 0, 1, 32'hbfc00204, 32'h3, 0, 0, 8'd0, 32'd0);
    idle(4, 32'd0);
    step(1, 0, 5'd0, 1, 0, 32'hbfc00300, 32'd0, 0, 1, 8'd0, 32'hbfc00420);
    idle(4, 32'hbfc00420);
    // Interrupt vs exception priority, then EXL masks the interrupt
    step(1, 1, 5'h0c, 0, 0, 32'hbfc00500, 32'h11, 1, 0, 8'h80, 32'd0);
    idle(4, 32'd0);
    step(1, 1, 5'h0c, 0, 0, 32'hbfc00500, 32'h11, 1, 1, 8'h80, 32'd0);
    idle(4, 32'd0);
    // Exceptions offered during FLUSH and DRAIN are dropped
    step(1, 1, 5'h08, 0, 0, 32'hbfc00600, 32'd0, 0, 0, 8'd0, 32'd0);
    step(1, 1, 5'h0a, 0, 0, 32'hbfc00604, 32'd0, 0, 0, 8'd0, 32'd0);
    step(1, 1, 5'h0a, 0, 0, 32'hbfc00608, 32'd0, 0, 0, 8'd0, 32'd0);
    idle(3, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) != 0, $urandom_range(5) == 0, 5'($urandom), $urandom_range(7) == 0,
           1'($urandom), {$urandom, 2'b00} >> 2 << 2, $urandom, 1'($urandom),
           $urandom_range(3) == 0, ($urandom_range(2) == 0) ? 8'($urandom) : 8'd0, $urandom);
    end
    idle(6, 32'd0);
    mon_en = 1'b0;
    chk("redirects_outstanding", 32'(rq.size()), 32'd0);
`ifdef EXC_STAT_EN
    chk("exc_count", exc_count, 32'(exp_exc_n));
    chk("eret_count", eret_count, 32'(exp_eret_n));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
